// File: rtl/sub_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub_sched_pkg
// Brief   : Shared types and size helpers for the nibble subtractor scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package sub_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shared subtractor slice
    localparam int NIB_W = 4;

    // Number of nibbles in a WIDTH-bit operand
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

    // Width of the nibble index counter (at least one bit)
    function automatic int k_width(input int width);
        return ((width / NIB_W) > 1) ? $clog2(width / NIB_W) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_sub.sv
`default_nettype none
// ============================================================================
// Module  : nibble_sub
// Brief   : 4-bit subtractor slice, diff = a + ~b + cin, four rippled full
//           adders. cout = 1 means no borrow out of this nibble.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] diff,
    output logic       cout
);

    logic [3:0] b_n;
    logic [4:0] c;

    assign b_n  = ~b;
    assign c[0] = cin;

    // One full adder per bit, carry rippling upward
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign diff[i]  = a[i] ^ b_n[i] ^ c[i];
        assign c[i + 1] = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end

    assign cout = c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_sub_sched.sv
`default_nettype none
// ============================================================================
// Module  : nibble_sub_sched
// Brief   : Round-robin arbiter and sequencer that time-shares one 4-bit
//           subtractor slice between two requesters, one nibble per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_sub_sched
    import sub_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_neg,
    output logic             out_id,
    output logic             busy
);

    localparam int NIB = nib_count(WIDTH);
    localparam int KW  = k_width(WIDTH);

    state_t                      state_q, state_d;
    logic                        last_q, last_d;   // id served most recently
    logic [KW-1:0]               k_q, k_d;         // nibble being computed
    logic                        carry_q, carry_d; // 1 = no borrow pending
    logic                        neg_q, neg_d;
    logic                        id_q, id_d;
    logic [NIB-1:0][NIB_W-1:0]   a_q, a_d;
    logic [NIB-1:0][NIB_W-1:0]   b_q, b_d;
    logic [NIB-1:0][NIB_W-1:0]   diff_q, diff_d;

    logic                        grant_any;
    logic                        grant_id;
    logic [NIB_W-1:0]            slice_diff;
    logic                        slice_cout;

    // Round-robin grant: a lone requester wins; on contention the one not
    // served last wins. Depends only on registered state and valids.
    always_comb begin
        grant_any = r0_valid | r1_valid;
        grant_id  = (r0_valid && r1_valid) ? ~last_q : r1_valid;
        r0_ready  = (state_q == IDLE) && grant_any && !grant_id;
        r1_ready  = (state_q == IDLE) && grant_any &&  grant_id;
    end

    // The single shared slice works on the nibble selected by k
    nibble_sub u_slice (
        .a    (a_q[k_q]),
        .b    (b_q[k_q]),
        .cin  (carry_q),
        .diff (slice_diff),
        .cout (slice_cout)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        k_d     = k_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = grant_id ? r1_a : r0_a;
                    b_d     = grant_id ? r1_b : r0_b;
                    id_d    = grant_id;
                    carry_d = 1'b1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[k_q] = slice_diff;
                carry_d     = slice_cout;
                k_d         = k_q + KW'(1);
                if (k_q == KW'(NIB - 1)) begin
                    neg_d   = ~slice_cout;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset pointer favours r0 (last = 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            k_q     <= '0;
            carry_q <= 1'b1;
            neg_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_diff  = diff_q;
    assign out_neg   = neg_q;
    assign out_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nibble_sub_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_sub_sched
// Brief   : Directed self-checking bench for nibble_sub_sched (WIDTH = 16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_sub_sched;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             r0_valid, r1_valid;
    logic             r0_ready, r1_ready;
    logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_neg, out_id, busy;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    nibble_sub_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_neg   (out_neg),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Present operands, expect the given grant, complete the handshake and
    // drop only the granted requester's valid.
    task automatic launch(input logic v0, input logic v1,
                          input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input logic exp_id);
        int n;
        r0_valid = v0;
        r1_valid = v1;
        r0_a = a0; r0_b = b0;
        r1_a = a1; r1_b = b1;
        #1;
        n = 0;
        while (!(r0_ready || r1_ready) && n < 20) begin
            step();
            n++;
        end
        check("grant", {30'd0, r1_ready, r0_ready}, exp_id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        if (exp_id) r1_valid = 1'b0;
        else        r0_valid = 1'b0;
    endtask

    // Called just after the accepting edge; result must appear after NIB edges
    task automatic wait_result(input logic [WIDTH-1:0] exp_diff, input logic exp_neg,
                               input logic exp_id);
        for (int i = 0; i < NIB - 1; i++) begin
            check("early_valid", {31'd0, out_valid}, 32'd0);
            check("busy_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
            step();
        end
        check("early_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_diff", {16'd0, out_diff}, {16'd0, exp_diff});
        check("out_neg", {31'd0, out_neg}, {31'd0, exp_neg});
        check("out_id", {31'd0, out_id}, {31'd0, exp_id});
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
        check("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_diff", {16'd0, out_diff}, 32'd0);
        check("rst_out_neg", {31'd0, out_neg}, 32'd0);
        check("rst_out_id", {31'd0, out_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Basic subtractions
        launch(1'b1, 1'b0, 16'h1234, 16'h0034, 16'h0, 16'h0, 1'b0);
        wait_result(16'h1200, 1'b0, 1'b0);
        consume();
        launch(1'b0, 1'b1, 16'h0, 16'h0, 16'h0001, 16'h0002, 1'b1);
        wait_result(16'hFFFF, 1'b1, 1'b1);
        consume();
        launch(1'b0, 1'b1, 16'h0, 16'h0, 16'hA5A5, 16'hA5A5, 1'b1);
        wait_result(16'h0000, 1'b0, 1'b1);
        consume();
        launch(1'b1, 1'b0, 16'h1000, 16'h0001, 16'h0, 16'h0, 1'b0);
        wait_result(16'h0FFF, 1'b0, 1'b0);
        consume();

        // Contention from reset: 0,1,0,1, then r1 alone after an r1 grant
        apply_reset();
        launch(1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0003, 16'h0010, 1'b0);
        wait_result(16'h00FF, 1'b0, 1'b0);
        consume();
        launch(1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0003, 16'h0010, 1'b1);
        wait_result(16'hFFF3, 1'b1, 1'b1);
        consume();
        launch(1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0003, 16'h0010, 1'b0);
        wait_result(16'h00FF, 1'b0, 1'b0);
        consume();
        launch(1'b1, 1'b1, 16'h0100, 16'h0001, 16'h0003, 16'h0010, 1'b1);
        wait_result(16'hFFF3, 1'b1, 1'b1);
        consume();
        launch(1'b0, 1'b1, 16'h0100, 16'h0001, 16'h0003, 16'h0010, 1'b1);
        wait_result(16'hFFF3, 1'b1, 1'b1);
        consume();

        // Back-pressure in DONE with both requesters waiting
        launch(1'b1, 1'b0, 16'h8000, 16'h0001, 16'h0003, 16'h0010, 1'b0);
        wait_result(16'h7FFF, 1'b0, 1'b0);
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_diff", {16'd0, out_diff}, 32'h7FFF);
            check("bp_neg", {31'd0, out_neg}, 32'd0);
            check("bp_id", {31'd0, out_id}, 32'd0);
            check("bp_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_grant", {30'd0, r1_ready, r0_ready}, 32'd2);
        launch(1'b1, 1'b1, 16'h8000, 16'h0001, 16'h0003, 16'h0010, 1'b1);
        wait_result(16'hFFF3, 1'b1, 1'b1);
        consume();
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Reset during the second RUN cycle aborts the operation
        launch(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 1'b0);
        step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_diff", {16'd0, out_diff}, 32'd0);
        check("mid_rst_neg", {31'd0, out_neg}, 32'd0);
        check("mid_rst_id", {31'd0, out_id}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_hold_valid", {31'd0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            step();
            check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        launch(1'b1, 1'b0, 16'h0005, 16'h0003, 16'h0, 16'h0, 1'b0);
        wait_result(16'h0002, 1'b0, 1'b0);
        consume();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_sub_sched.md
# nibble_sub_sched

Sequencer and arbiter for the shared 4-bit nibble subtractor slice. Two requesters (e.g. the old-rank and new-rank difference paths of the PageRank update) submit WIDTH-bit unsigned subtractions; the block grants one round-robin, computes a − b one nibble per cycle with borrow chained across cycles, and returns the difference plus a negative flag over a valid/ready handshake. It replaces per-requester wide subtractors with a single time-shared 4-bit slice.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8. NIB = WIDTH/4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- r0_valid / r1_valid  in  1  requester has an operand pair
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  unsigned minuend, subtrahend
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_diff  out  WIDTH  (a − b) mod 2^WIDTH
- out_neg  out  1  1 when a < b (unsigned)
- out_id  out  1  requester index of the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - grant = requester with valid high; if both, the one not served last.
  - Pointer resets to favour r0.
  - rX_ready = (state==IDLE) && grant==X; combinational; at most one high.
  - On handshake: latch a, b, id; carry ← 1; k ← 0; → RUN.
- RUN, each cycle:
  - Slice computes a[4k+3:4k] + ~b[4k+3:4k] + carry.
  - Nibble k of diff register ← sum; carry ← carry-out (carry-out 1 means no borrow); k ← k+1.
  - After nibble NIB−1 → DONE.
- DONE:
  - out_valid=1; out_neg = ~carry.
  - On out_valid && out_ready: → IDLE; pointer ← served id.
- Inputs are ignored while busy; the rX_ready outputs stay 0.
- out_diff, out_neg and out_id are registered and must hold stable while out_valid=1 and out_ready=0.
- Equal operands: diff 0, out_neg 0.

## Timing
- Reset values: r0_ready=r1_ready=0 (no valid), out_valid=0, out_diff=0, out_neg=0, out_id=0, busy=0; state IDLE; pointer favours r0.
- Latency: out_valid rises exactly NIB cycles after the accepting clock edge (4 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles when out_ready is held high. DONE→IDLE costs one cycle; the next accept happens in IDLE.
- No combinational path from out_ready to rX_ready.
- An asynchronous reset in RUN or DONE aborts the operation: the result is discarded, out_valid is never raised for it, and all outputs take their reset values immediately.
- A requester may drop valid before ready without effect; only handshaked operands are used.

## Structure
- Package sub_sched_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - constant NIB_W = 4;
  - localparam-style helper for NIB and the k counter width ($clog2(NIB)).
- Sub-module nibble_sub is the single shared slice:
  - ports: a[3:0], b[3:0], cin, diff[3:0], cout;
  - function: a + ~b + cin, ripple of four full adders.
- Scheduler logic is the FSM, RR pointer, operand/result registers and nibble mux. It stays in nibble_sub_sched.

## Test plan
- r0: a=0x1234, b=0x0034 → out_diff=0x1200, out_neg=0, out_id=0, out_valid exactly 4 cycles after accept.
- r1: a=0x0001, b=0x0002 → out_diff=0xFFFF, out_neg=1; then a=b=0xA5A5 → 0x0000, out_neg=0.
- Borrow ripple across all nibbles: a=0x1000, b=0x0001 → 0x0FFF, out_neg=0.
- Contention arbitration:
  - both valid from reset → r0 served first, r1 next;
  - repeated dual-valid runs alternate 0,1,0,1;
  - r1 alone after an r1 grant is still served.
- Back-pressure: out_ready low 5 cycles in DONE → outputs stable, r0_ready/r1_ready stay 0 despite valid; release → IDLE next cycle, then accept.
- Mid-operation reset: rst_n low during the 2nd RUN cycle → all outputs 0 immediately, no out_valid; after release, r0 0x0005−0x0003 → 0x0002.
